bus_bridge_io: RTL
==================

// Module: bus_bridge_io
// PURPOSE
//  Responder end of the CPU data bus (Bus_addr/Bus_rdata/Bus_wen/Bus_wdata).
//  Decodes each access to external DRAM or to on-chip MMIO: LED, switches,
//  buttons, an 8-digit 7-segment scanner and a prescaled 32-bit timer.
//  Sits between myCPU and the board I/O. Reads are combinational so the
//  single-cycle core completes a load in the same cycle.
// PARAMETERS
//  DRAM_AW           14       DRAM word-address width; dram_addr = Bus_addr[DRAM_AW+1:2]
//  SCAN_DIV          50000    cpu_clk cycles per 7-seg digit slot (>=2)
//  DEFAULT_PRESCALE  0        timer prescale reset value
// PORTS
//  cpu_clk    in   1        clock; all state updates on rising edge
//  cpu_rst    in   1        reset, synchronous, active-low (0 = reset)
//  Bus_addr   in   32       byte address from CPU
//  Bus_wen    in   1        write strobe, 1 = write this cycle
//  Bus_wdata  in   32       write data
//  Bus_rdata  out  32       read data, combinational from Bus_addr
//  dram_addr  out  DRAM_AW  DRAM word address
//  dram_wen   out  1        DRAM write enable
//  dram_wdata out  32       = Bus_wdata
//  dram_rdata in   32       DRAM async read data
//  sw         in   24       raw switches
//  btn        in   5        raw buttons
//  led        out  24       LED register
//  dig_en     out  8        digit enables, active-low, one-cold
//  dig_seg    out  8        segments {dp,g,f,e,d,c,b,a}, active-low
// BEHAVIOUR
//  Decode: Bus_addr[31:12]==20'hFFFFF -> MMIO page; else DRAM.
//  MMIO map (full-address match; other page offsets: read 0, write ignored):
//   F000 SEG  RW 32b: 8 hex digits; digit k = SEG[4k+3:4k]
//   F020 TCNT RW 32b  | F024 TPRE RW 32b | F060 LED RW 24b (read zero-ext)
//   F070 SW   RO 24b (zero-ext)          | F078 BTN RO 5b (zero-ext)
//  dram_wen = Bus_wen & dram_sel & cpu_rst; MMIO write/read never asserts it.
//  MMIO writes take effect at the next edge when Bus_wen=1; writes to RO ignored.
//  Bus_rdata: dram_sel ? dram_rdata : MMIO mux; no extra latency.
//  sw/btn: 2-flop synchronisers; read shows pin value after 2 edges.
//  Timer: prescale counter pcnt. Each edge: if pcnt==TPRE {pcnt<=0; TCNT<=TCNT+1}
//   else pcnt<=pcnt+1. TPRE=0 -> +1 every cycle. TCNT wraps FFFFFFFF->0.
//   Write TCNT: TCNT<=wdata, pcnt<=0; write wins over same-edge increment.
//   Write TPRE: TPRE<=wdata, pcnt<=0.
//  Scanner: scnt counts 0..SCAN_DIV-1; at SCAN_DIV-1 wraps and idx<=idx+1 (mod 8).
//   Registered outputs each edge: dig_en<=~(1<<idx); dig_seg<=hex7seg(SEG digit idx),
//   dp always off. Codes: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90
//   A=88 b=83 C=C6 d=A1 E=86 F=8E. SEG update visible within one edge.
//  Reset (cpu_rst=0 at edge): led=0, SEG=0, TCNT=0, TPRE=DEFAULT_PRESCALE,
//   pcnt=0, scnt=0, idx=0, sync flops=0, dig_en=FF, dig_seg=FF. Bus writes during
//   reset are dropped; reset mid-count overrides any same-edge write/increment.
// TESTING
//  1 write F060 data 00A5A5A5 -> led=A5A5A5 after edge; read F060 = 00A5A5A5; dram_wen=0.
//  2 write addr 00000010 data DEADBEEF -> dram_wen=1, dram_addr=4, led unchanged;
//    read 00000010 returns dram_rdata same cycle.
//  3 TPRE<=3, TCNT<=0 -> TCNT reads 1 after 4 edges, 2 after 8; TPRE=0, TCNT<=FFFFFFFF
//    -> 0 next edge; TCNT write 10 on increment edge -> reads 10.
//  4 SCAN_DIV=4, SEG<=76543210 -> dig_en FE,FD,FB..7F, 4 cycles each, wraps to FE;
//    dig_seg C0 with FE, F9 with FD.
//  5 sw=123456 -> read F070 = 0 for first 2 edges, 00123456 after; read F004 = 0.
//  6 timer running, led=FF: cpu_rst=0 one edge with Bus_wen=1 to F060 and DRAM ->
//    all regs at reset values, led=0, dram_wen=0 during reset.

Source files
------------

// File: rtl/bus_bridge_io.sv
// bus_bridge_io
//   Responder end of the CPU data bus. Each access is decoded either to
//   external DRAM or to the on-chip MMIO page at 0xFFFFF000. The MMIO page
//   holds the LED register, synchronised switches and buttons, an 8-digit
//   7-segment scanner and a prescaled 32-bit timer.
//
// Bus protocol: there is no handshake. Every cycle is one access. Bus_addr
// selects the target. Bus_wen=1 means the access is a write that commits at
// the next rising edge of cpu_clk. Bus_rdata is purely combinational from
// Bus_addr, so a single-cycle core completes a load in the same cycle.
//
// Ports
//   cpu_clk     in   clock, all state updates on the rising edge
//   cpu_rst     in   synchronous reset, active-low (0 = reset)
//   Bus_addr    in   32-bit byte address from the CPU
//   Bus_wen     in   write strobe
//   Bus_wdata   in   32-bit write data
//   Bus_rdata   out  32-bit read data (combinational)
//   dram_addr   out  DRAM word address, Bus_addr[DRAM_AW+1:2]
//   dram_wen    out  DRAM write enable
//   dram_wdata  out  DRAM write data (= Bus_wdata)
//   dram_rdata  in   DRAM asynchronous read data
//   sw          in   raw switches (24)
//   btn         in   raw buttons (5)
//   led         out  LED register (24)
//   dig_en      out  digit enables, active-low, one-cold
//   dig_seg     out  segments {dp,g,f,e,d,c,b,a}, active-low
module bus_bridge_io #(
  parameter int          DRAM_AW          = 14,
  parameter int          SCAN_DIV         = 50000,
  parameter logic [31:0] DEFAULT_PRESCALE = 32'd0
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  input  logic [31:0]        Bus_addr,
  input  logic               Bus_wen,
  input  logic [31:0]        Bus_wdata,
  output logic [31:0]        Bus_rdata,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic               dram_wen,
  output logic [31:0]        dram_wdata,
  input  logic [31:0]        dram_rdata,
  input  logic [23:0]        sw,
  input  logic [4:0]         btn,
  output logic [23:0]        led,
  output logic [7:0]         dig_en,
  output logic [7:0]         dig_seg
);

  // Scan counter width; SCAN_DIV is at least 2, so $clog2 is at least 1.
  localparam int                SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  // MMIO page offsets (low 12 bits of the byte address)
  localparam logic [19:0] MMIO_PAGE = 20'hFFFFF;
  localparam logic [11:0] OFF_SEG   = 12'h000;
  localparam logic [11:0] OFF_TCNT  = 12'h020;
  localparam logic [11:0] OFF_TPRE  = 12'h024;
  localparam logic [11:0] OFF_LED   = 12'h060;
  localparam logic [11:0] OFF_SW    = 12'h070;
  localparam logic [11:0] OFF_BTN   = 12'h078;

  // ---------------------------------------------------------------------
  // Hex digit to active-low 7-segment code, dp bit held off (1).
  // ---------------------------------------------------------------------
  function automatic logic [7:0] hex7seg(input logic [3:0] d);
    logic [7:0] code;
    case (d)
      4'h0:    code = 8'hC0;
      4'h1:    code = 8'hF9;
      4'h2:    code = 8'hA4;
      4'h3:    code = 8'hB0;
      4'h4:    code = 8'h99;
      4'h5:    code = 8'h92;
      4'h6:    code = 8'h82;
      4'h7:    code = 8'hF8;
      4'h8:    code = 8'h80;
      4'h9:    code = 8'h90;
      4'hA:    code = 8'h88;
      4'hB:    code = 8'h83;
      4'hC:    code = 8'hC6;
      4'hD:    code = 8'hA1;
      4'hE:    code = 8'h86;
      default: code = 8'h8E;
    endcase
    return code;
  endfunction

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic        mmio_sel;
  logic        dram_sel;
  logic [11:0] offset;
  logic        wr_mmio;
  logic        wr_seg;
  logic        wr_tcnt;
  logic        wr_tpre;
  logic        wr_led;

  assign mmio_sel = (Bus_addr[31:12] == MMIO_PAGE);
  assign dram_sel = ~mmio_sel;
  assign offset   = Bus_addr[11:0];

  // MMIO writes are only honoured out of reset; the register blocks below
  // also give reset priority, so a write during reset is dropped.
  assign wr_mmio = Bus_wen & mmio_sel & cpu_rst;
  assign wr_seg  = wr_mmio & (offset == OFF_SEG);
  assign wr_tcnt = wr_mmio & (offset == OFF_TCNT);
  assign wr_tpre = wr_mmio & (offset == OFF_TPRE);
  assign wr_led  = wr_mmio & (offset == OFF_LED);

  // DRAM side: address and data pass straight through; the write enable is
  // masked by reset so nothing reaches DRAM while the core is held.
  assign dram_addr  = Bus_addr[DRAM_AW+1:2];
  assign dram_wdata = Bus_wdata;
  assign dram_wen   = Bus_wen & dram_sel & cpu_rst;

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  logic [31:0] seg_reg;
  logic [31:0] tcnt;
  logic [31:0] tpre;
  logic [31:0] pcnt;
  logic [23:0] led_reg;
  logic [23:0] sw_meta;
  logic [23:0] sw_sync;
  logic [4:0]  btn_meta;
  logic [4:0]  btn_sync;
  logic [SCAN_W-1:0] scnt;
  logic [2:0]  idx;

  assign led = led_reg;

  // LED and SEG registers
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) begin
      led_reg <= '0;
      seg_reg <= '0;
    end else begin
      if (wr_led) led_reg <= Bus_wdata[23:0];
      if (wr_seg) seg_reg <= Bus_wdata;
    end
  end

  // Two-flop synchronisers for the asynchronous board inputs
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
      btn_meta <= btn;
      btn_sync <= btn_meta;
    end
  end

  // Timer: pcnt counts 0..TPRE, and TCNT advances on the cycle pcnt hits
  // TPRE. Register writes come last so they override the same-edge
  // increment and restart the prescaler.
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) begin
      tcnt <= '0;
      tpre <= DEFAULT_PRESCALE;
      pcnt <= '0;
    end else begin
      if (pcnt == tpre) begin
        pcnt <= '0;
        tcnt <= tcnt + 32'd1;
      end else begin
        pcnt <= pcnt + 32'd1;
      end
      if (wr_tpre) begin
        tpre <= Bus_wdata;
        pcnt <= '0;
      end
      if (wr_tcnt) begin
        tcnt <= Bus_wdata;
        pcnt <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // 7-segment scanner
  // ---------------------------------------------------------------------
  // The segment pattern is taken from the value SEG will hold after this
  // edge, so a SEG write shows on dig_seg at the same edge it commits.
  logic [31:0] seg_nxt;
  logic [3:0]  cur_digit;

  assign seg_nxt   = wr_seg ? Bus_wdata : seg_reg;
  assign cur_digit = seg_nxt[{idx, 2'b00} +: 4];

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) begin
      scnt    <= '0;
      idx     <= '0;
      dig_en  <= 8'hFF;
      dig_seg <= 8'hFF;
    end else begin
      if (scnt == SCAN_LAST) begin
        scnt <= '0;
        idx  <= idx + 3'd1;
      end else begin
        scnt <= scnt + SCAN_W'(1);
      end
      dig_en  <= ~(8'b0000_0001 << idx);
      dig_seg <= hex7seg(cur_digit);
    end
  end

  // ---------------------------------------------------------------------
  // Read mux. Unmapped MMIO offsets read as zero.
  // ---------------------------------------------------------------------
  logic [31:0] mmio_rdata;

  always_comb begin
    mmio_rdata = 32'd0;
    case (offset)
      OFF_SEG:  mmio_rdata = seg_reg;
      OFF_TCNT: mmio_rdata = tcnt;
      OFF_TPRE: mmio_rdata = tpre;
      OFF_LED:  mmio_rdata = {8'd0, led_reg};
      OFF_SW:   mmio_rdata = {8'd0, sw_sync};
      OFF_BTN:  mmio_rdata = {27'd0, btn_sync};
      default:  mmio_rdata = 32'd0;
    endcase
  end

  assign Bus_rdata = dram_sel ? dram_rdata : mmio_rdata;

endmodule
